// File: rtl/lcd_nios2_qsys_0_oci_dct_packer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | lcd_nios2_qsys_0_oci_dct_packer                                          |
// | Packs 2-bit debug-trace codes into words with an end-of-test flush.      |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
module lcd_nios2_qsys_0_oci_dct_packer #(
  parameter int CODE_W = 2,
  parameter int DEPTH  = 15,
  parameter int BUF_W  = CODE_W * DEPTH
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              code_valid,
  input  logic [CODE_W-1:0] code,
  output logic              code_ready,
  input  logic              flush,
  output logic [BUF_W-1:0]  dct_buffer,
  output logic [3:0]        dct_count,
  output logic              word_valid,
  input  logic              word_ready,
  output logic [BUF_W-1:0]  word_buffer,
  output logic [3:0]        word_count,
  output logic              test_ending,
  output logic              test_has_ended
);

  typedef enum logic [1:0] {
    ST_FILL  = 2'd0,
    ST_DRAIN = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic [3:0] C_LAST_CNT = 4'(DEPTH - 1);
  localparam logic [3:0] C_FULL_CNT = 4'(DEPTH);

  state_t             state_q, state_d;
  logic [BUF_W-1:0]   dct_buffer_q, dct_buffer_d;
  logic [3:0]         dct_count_q, dct_count_d;
  logic               word_valid_q, word_valid_d;
  logic [BUF_W-1:0]   word_buffer_q, word_buffer_d;
  logic [3:0]         word_count_q, word_count_d;
  logic               test_ending_q, test_ending_d;
  logic               test_has_ended_q, test_has_ended_d;

  logic [BUF_W-1:0]   w_shifted;
  logic               w_accept;
  logic               w_handshake;
  logic               w_out_free;

  generate
    if (DEPTH > 1) begin : g_shift
      assign w_shifted = {dct_buffer_q[BUF_W-CODE_W-1:0], code};
    end else begin : g_single
      assign w_shifted = code;
    end
  endgenerate

  // Depends only on registered state so word_ready never reaches code_ready.
  assign code_ready  = (state_q == ST_FILL) &&
                       !((dct_count_q == C_LAST_CNT) && word_valid_q);
  assign w_accept    = code_valid && code_ready;
  assign w_handshake = word_valid_q && word_ready;
  assign w_out_free  = !word_valid_q || w_handshake;

  always_comb begin
    state_d          = state_q;
    dct_buffer_d     = dct_buffer_q;
    dct_count_d      = dct_count_q;
    word_valid_d     = word_valid_q && !w_handshake;
    word_buffer_d    = word_buffer_q;
    word_count_d     = word_count_q;
    test_ending_d    = test_ending_q;
    test_has_ended_d = test_has_ended_q;

    case (state_q)
      ST_FILL: begin
        if (w_accept) begin
          if (dct_count_q == C_LAST_CNT) begin
            word_buffer_d = w_shifted;
            word_count_d  = C_FULL_CNT;
            word_valid_d  = 1'b1;
            dct_buffer_d  = '0;
            dct_count_d   = '0;
          end else begin
            dct_buffer_d  = w_shifted;
            dct_count_d   = dct_count_q + 4'd1;
          end
        end
        if (flush) begin
          state_d       = ST_DRAIN;
          test_ending_d = 1'b1;
        end
      end
      ST_DRAIN: begin
        if (w_out_free) begin
          if (dct_count_q != 4'd0) begin
            word_buffer_d = dct_buffer_q;
            word_count_d  = dct_count_q;
            word_valid_d  = 1'b1;
            dct_buffer_d  = '0;
            dct_count_d   = '0;
          end else begin
            state_d          = ST_DONE;
            test_has_ended_d = 1'b1;
          end
        end
      end
      ST_DONE: begin
      end
      default: begin
        state_d = ST_FILL;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q          <= ST_FILL;
      dct_buffer_q     <= '0;
      dct_count_q      <= '0;
      word_valid_q     <= 1'b0;
      word_buffer_q    <= '0;
      word_count_q     <= '0;
      test_ending_q    <= 1'b0;
      test_has_ended_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      dct_buffer_q     <= dct_buffer_d;
      dct_count_q      <= dct_count_d;
      word_valid_q     <= word_valid_d;
      word_buffer_q    <= word_buffer_d;
      word_count_q     <= word_count_d;
      test_ending_q    <= test_ending_d;
      test_has_ended_q <= test_has_ended_d;
    end
  end

  assign dct_buffer     = dct_buffer_q;
  assign dct_count      = dct_count_q;
  assign word_valid     = word_valid_q;
  assign word_buffer    = word_buffer_q;
  assign word_count     = word_count_q;
  assign test_ending    = test_ending_q;
  assign test_has_ended = test_has_ended_q;

endmodule
`default_nettype wire
